// File: rtl/backend_types_pkg.sv
// rtl/backend_types_pkg.sv - branch tag types shared by dispatch, the tag controller and execution units
package backend_types;

  localparam int NUM_BRANCH_TAGS = 4;
  localparam int BRANCH_TAG_W    = $clog2(NUM_BRANCH_TAGS);

  typedef logic [BRANCH_TAG_W-1:0]    branch_tag_t;
  typedef logic [NUM_BRANCH_TAGS-1:0] branch_mask_t;

endpackage

// File: rtl/brb_itf.sv
// rtl/brb_itf.sv - branch resolution broadcast bus from the tag controller to every execution unit
interface brb_itf #(
  parameter int NUM_TAGS = backend_types::NUM_BRANCH_TAGS
);

  logic                        broadcast;
  logic [$clog2(NUM_TAGS)-1:0] tag;
  logic                        clean;
  logic                        kill;

  modport responder (output broadcast, tag, clean, kill);
  modport requester (input  broadcast, tag, clean, kill);

endinterface

// File: rtl/branch_tag_ctrl_free_tag_finder.sv
// rtl/branch_tag_ctrl_free_tag_finder.sv - lowest-set-bit priority encoder over the free-tag vector
module free_tag_finder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         free,
  output logic [$clog2(N)-1:0] tag,
  output logic                 found
);

  localparam int W = $clog2(N);

  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    tag   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        tag   = i[W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_tag_ctrl.sv
// rtl/branch_tag_ctrl.sv - allocates branch tags, tracks their dependencies and broadcasts resolutions
module branch_tag_ctrl
  import backend_types::*;
#(
  parameter int NUM_TAGS = NUM_BRANCH_TAGS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  output logic                        alloc_ready,
  output logic [$clog2(NUM_TAGS)-1:0] alloc_tag,
  output logic [NUM_TAGS-1:0]         cur_mask,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [$clog2(NUM_TAGS)-1:0] res_tag,
  input  logic                        res_taken,
  input  logic                        res_pred,
  brb_itf.responder                   brif
);

  localparam int TW = $clog2(NUM_TAGS);

  logic [NUM_TAGS-1:0] valid_q;
  logic [NUM_TAGS-1:0] dep_q [NUM_TAGS];
  logic                bc_q;
  logic                bc_clean_q;
  logic [TW-1:0]       bc_tag_q;

  logic                found;
  logic [TW-1:0]       free_tag;
  logic                bc_kill;
  logic                bc_clean;
  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] clean_bit;
  logic [NUM_TAGS-1:0] alloc_bit;
  logic                alloc_fire;
  logic                res_accept;

  free_tag_finder #(.N(NUM_TAGS)) u_finder (
    .free  (~valid_q),
    .tag   (free_tag),
    .found (found)
  );

  always_comb begin
    bc_kill   = bc_q & ~bc_clean_q;
    bc_clean  = bc_q & bc_clean_q;
    free_mask = '0;
    clean_bit = '0;
    alloc_bit = '0;
    if (bc_q) begin
      free_mask[bc_tag_q] = 1'b1;
    end
    if (bc_clean) begin
      clean_bit[bc_tag_q] = 1'b1;
    end
    // A kill also squashes every tag allocated while the mispredicted one was live.
    if (bc_kill) begin
      for (int u = 0; u < NUM_TAGS; u++) begin
        if (dep_q[u][bc_tag_q]) begin
          free_mask[u] = 1'b1;
        end
      end
    end
    alloc_ready = found & ~bc_kill;
    alloc_fire  = alloc_req & alloc_ready;
    if (alloc_fire) begin
      alloc_bit[free_tag] = 1'b1;
    end
    res_ready  = rst;
    // Resolutions for tags being retired or squashed this cycle are stale.
    res_accept = res_valid & rst & valid_q[res_tag] & ~free_mask[res_tag];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      bc_q       <= 1'b0;
      bc_clean_q <= 1'b0;
      bc_tag_q   <= '0;
      for (int u = 0; u < NUM_TAGS; u++) begin
        dep_q[u] <= '0;
      end
    end else begin
      valid_q <= (valid_q & ~free_mask) | alloc_bit;
      for (int u = 0; u < NUM_TAGS; u++) begin
        dep_q[u] <= dep_q[u] & ~clean_bit;
      end
      if (alloc_fire) begin
        dep_q[free_tag] <= valid_q & ~clean_bit;
      end
      bc_q       <= res_accept;
      bc_tag_q   <= res_tag;
      bc_clean_q <= (res_taken == res_pred);
    end
  end

  assign alloc_tag      = free_tag;
  assign cur_mask       = valid_q;
  assign brif.broadcast = bc_q;
  assign brif.tag       = bc_tag_q;
  assign brif.clean     = bc_clean;
  assign brif.kill      = bc_kill;

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// tb/tb_branch_tag_ctrl.sv - directed vector bench for branch_tag_ctrl
module tb_branch_tag_ctrl;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ready;
  logic [1:0] alloc_tag;
  logic [3:0] cur_mask;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_tag;
  logic       res_taken;
  logic       res_pred;

  int checks = 0;
  int errors = 0;

  brb_itf #(.NUM_TAGS(4)) bus ();

  branch_tag_ctrl #(.NUM_TAGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cur_mask    (cur_mask),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_tag     (res_tag),
    .res_taken   (res_taken),
    .res_pred    (res_pred),
    .brif        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, req, rv;
    logic [1:0] rt;
    logic       tk, pd;
    logic       chk;
    logic       ardy;
    logic [1:0] atag;
    logic       tcare;
    logic [3:0] mask;
    logic       rrdy, bc;
    logic [1:0] btag;
    logic       cl, kl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int r, q, v, t, k, p, c, ar, at, tc, m, rr, b, bt, cl, kl);
    vec_t x;
    x.rst = r[0];  x.req = q[0];  x.rv = v[0];   x.rt = t[1:0];
    x.tk = k[0];   x.pd = p[0];   x.chk = c[0];  x.ardy = ar[0];
    x.atag = at[1:0]; x.tcare = tc[0]; x.mask = m[3:0]; x.rrdy = rr[0];
    x.bc = b[0];   x.btag = bt[1:0]; x.cl = cl[0]; x.kl = kl[0];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
  task automatic cyc(input int r, q, v, t, k, p);
    @(negedge clk);
    rst       = r[0];
    alloc_req = q[0];
    res_valid = v[0];
    res_tag   = t[1:0];
    res_taken = k[0];
    res_pred  = p[0];
    #1;
  endtask

  initial begin
    rst = 1'b0; alloc_req = 1'b0; res_valid = 1'b0;
    res_tag = 2'd0; res_taken = 1'b0; res_pred = 1'b0;

    //             rst q v t k p  chk ardy atag tc mask rr bc bt cl kl
    tbl.push_back(mk(0, 0,0,0,0,0, 0, 0,0,0, 'h0, 0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1, 1,0,1, 'h0, 0, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,0,1, 'h0, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,1,1, 'h1, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,2,1, 'h3, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,3,1, 'h7, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 0,0,0, 'hF, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 0,0,0, 'hF, 1, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1, 0,0,0, 'hF, 0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 1,0,1, 'h0, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,0,1, 'h0, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,1,1, 'h1, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,1,0,1,1, 1, 1,2,1, 'h3, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 1,2,1, 'h3, 1, 1,0,1,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,0,1, 'h2, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,1,0,1,0, 1, 1,2,1, 'h3, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 0,0,0, 'h3, 1, 1,0,0,1));
    tbl.push_back(mk(1, 0,1,1,0,0, 1, 1,0,1, 'h2, 1, 0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,0,1, 'h2, 1, 1,1,1,0));
    tbl.push_back(mk(1, 1,0,0,0,0, 1, 1,1,1, 'h1, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,1,1,1,0, 1, 1,2,1, 'h3, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 0,0,0, 'h3, 1, 1,1,0,1));
    tbl.push_back(mk(1, 0,1,0,0,0, 1, 1,1,1, 'h1, 1, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 1,1,1, 'h1, 1, 1,0,1,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1, 1,0,1, 'h0, 1, 0,0,0,0));

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].rv, tbl[i].rt, tbl[i].tk, tbl[i].pd);
      if (tbl[i].chk) begin
        chk($sformatf("row%0d alloc_ready", i), 32'(alloc_ready), 32'(tbl[i].ardy));
        if (tbl[i].tcare) chk($sformatf("row%0d alloc_tag", i), 32'(alloc_tag), 32'(tbl[i].atag));
        chk($sformatf("row%0d cur_mask", i), 32'(cur_mask), 32'(tbl[i].mask));
        chk($sformatf("row%0d res_ready", i), 32'(res_ready), 32'(tbl[i].rrdy));
        chk($sformatf("row%0d broadcast", i), 32'(bus.broadcast), 32'(tbl[i].bc));
        chk($sformatf("row%0d clean", i), 32'(bus.clean), 32'(tbl[i].cl));
        chk($sformatf("row%0d kill", i), 32'(bus.kill), 32'(tbl[i].kl));
        if (tbl[i].bc) chk($sformatf("row%0d brif_tag", i), 32'(bus.tag), 32'(tbl[i].btag));
      end
    end

    // Mispredict with younger tags: kill tag 1 squashes tag 2, tag 1 is reusable afterwards.
    cyc(1, 1,0,0,0,0); chk("mp alloc0", 32'(alloc_tag), 32'd0);
    cyc(1, 1,0,0,0,0); chk("mp alloc1", 32'(alloc_tag), 32'd1);
    cyc(1, 1,0,0,0,0); chk("mp alloc2", 32'(alloc_tag), 32'd2);
    cyc(1, 0,1,1,1,0); chk("mp mask_pre", 32'(cur_mask), 32'h7);
    cyc(1, 0,0,0,0,0);
    chk("mp broadcast", 32'(bus.broadcast), 32'd1);
    chk("mp tag", 32'(bus.tag), 32'd1);
    chk("mp kill", 32'(bus.kill), 32'd1);
    chk("mp alloc_ready_in_kill", 32'(alloc_ready), 32'd0);
    cyc(1, 0,0,0,0,0);
    chk("mp mask_post", 32'(cur_mask), 32'h1);
    chk("mp next_tag", 32'(alloc_tag), 32'd1);
    cyc(1, 1,0,0,0,0); chk("mp realloc_ready", 32'(alloc_ready), 32'd1);
    cyc(1, 0,0,0,0,0); chk("mp realloc_mask", 32'(cur_mask), 32'h3);

    // Race: kill of tag 0 is broadcast while a resolution for dependent tag 2 arrives.
    cyc(1, 1,0,0,0,0); chk("race alloc2", 32'(alloc_tag), 32'd2);
    cyc(1, 0,1,0,1,0); chk("race mask_pre", 32'(cur_mask), 32'h7);
    cyc(1, 0,1,2,1,1);
    chk("race kill0", 32'(bus.kill), 32'd1);
    chk("race kill_tag", 32'(bus.tag), 32'd0);
    cyc(1, 0,0,0,0,0);
    chk("race no_bc", 32'(bus.broadcast), 32'd0);
    chk("race mask_post", 32'(cur_mask), 32'h0);
    cyc(1, 0,0,0,0,0); chk("race no_bc2", 32'(bus.broadcast), 32'd0);

    // Stale resolution for a tag that is not live.
    cyc(1, 1,0,0,0,0); chk("stale alloc0", 32'(alloc_tag), 32'd0);
    cyc(1, 0,1,3,1,1); chk("stale mask_pre", 32'(cur_mask), 32'h1);
    cyc(1, 0,0,0,0,0);
    chk("stale no_bc", 32'(bus.broadcast), 32'd0);
    chk("stale mask", 32'(cur_mask), 32'h1);
    cyc(1, 0,0,0,0,0);
    chk("stale no_bc2", 32'(bus.broadcast), 32'd0);
    chk("stale next_tag", 32'(alloc_tag), 32'd1);

    // Reset while a resolution is registered.
    cyc(1, 0,1,0,1,1);
    cyc(0, 0,0,0,0,0);
    chk("rst bc_pending", 32'(bus.broadcast), 32'd1);
    chk("rst res_ready", 32'(res_ready), 32'd0);
    cyc(1, 0,0,0,0,0);
    chk("rst no_bc", 32'(bus.broadcast), 32'd0);
    chk("rst mask", 32'(cur_mask), 32'h0);
    chk("rst alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst alloc_ready", 32'(alloc_ready), 32'd1);
    cyc(1, 0,0,0,0,0); chk("rst no_bc2", 32'(bus.broadcast), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_tag_ctrl.md
BRANCH_TAG_CTRL -- requirements
Module: branch_tag_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAGS, default NUM_BRANCH_TAGS (4), giving the number of in-flight branch tags and the branch_mask width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port alloc_req, input, 1 bit: dispatch requests a tag for a new branch.
REQ-005 SHALL have port alloc_ready, output, 1 bit: a tag can be granted this cycle.
REQ-006 SHALL have port alloc_tag, output, $clog2(NUM_TAGS) bits: the tag granted when alloc_req and alloc_ready are both high.
REQ-007 SHALL have port cur_mask, output, NUM_TAGS bits: the live-tag mask that dispatch stamps into meta.branch_mask.
REQ-008 SHALL have port res_valid, input, 1 bit: the comparator reply holds a resolved branch.
REQ-009 SHALL have port res_ready, output, 1 bit: a resolution can be accepted.
REQ-010 SHALL have port res_tag, input, $clog2(NUM_TAGS) bits: the resolving branch's own tag.
REQ-011 SHALL have port res_taken, input, 1 bit: the comparator result bit 0.
REQ-012 SHALL have port res_pred, input, 1 bit: the predicted direction.
REQ-013 SHALL have port brif, brb_itf responder modport: drives broadcast, tag, clean and kill to every execution unit.

Function
REQ-014 SHALL hold per-tag state: valid bit and dep_mask[NUM_TAGS], the set of tags live when that tag was allocated.
REQ-015 SHALL drive alloc_ready = (free tag exists) AND NOT (brif.broadcast AND brif.kill).
REQ-016 SHALL drive alloc_tag = the lowest-index invalid tag.
REQ-017 SHALL perform the allocation handshake as follows: on alloc_req AND alloc_ready, set valid[alloc_tag] and set dep_mask[alloc_tag] = cur_mask.
REQ-018 SHALL drive cur_mask = the valid vector, combinationally from registered state.
REQ-019 SHALL tie res_ready to 1 outside reset, accepting one resolution per cycle.
REQ-020 SHALL define a resolution as accepted on res_valid AND res_ready, and ignore it when valid[res_tag] = 0.
REQ-021 SHALL register each accepted resolution so that brif.broadcast = 1 exactly one cycle later, with brif.tag = res_tag.
REQ-022 SHALL, for that broadcast, set brif.clean = (res_taken == res_pred) and brif.kill = the inverse of brif.clean.
REQ-023 SHALL keep brif.broadcast, brif.clean and brif.kill at 0 in every cycle with no registered resolution.
REQ-024 SHALL, on the cycle a clean for tag t is broadcast, clear valid[t] and clear bit t in every dep_mask.
REQ-025 SHALL, on the cycle a kill for tag t is broadcast, clear valid[t] and valid[u] for every u whose dep_mask[u][t] = 1.
REQ-026 SHALL make tags freed by a broadcast allocatable from the next cycle only; alloc_tag never equals a tag freed in the same cycle.
REQ-027 SHALL, when a resolution arrives for tag u while a kill covering u is broadcast, drop that resolution with no later broadcast.
REQ-028 SHALL, on simultaneous allocation and clean broadcast, compute the new dep_mask from the pre-clean cur_mask with bit t cleared.
REQ-029 SHALL, when full (all valid), hold alloc_ready = 0 and alloc_tag as don't-care, with no state change on alloc_req.
REQ-030 SHALL, with zero tags valid, cause no broadcast and drive cur_mask = 0.

Reset
REQ-031 SHALL, on a clock edge with rst = 0, clear all valid bits, dep_masks and the registered resolution, including any resolution pending from the prior cycle.
REQ-032 SHALL hold outputs during and immediately after reset at: alloc_ready = 1, alloc_tag = 0, cur_mask = 0, res_ready = 0 while in reset, brif.broadcast/clean/kill = 0.

Structure
REQ-033 SHALL place NUM_BRANCH_TAGS, branch_tag_t and branch_mask_t in backend_types, shared with the execution units.
REQ-034 SHALL instantiate one sub-module, free_tag_finder, a lowest-set-bit priority encoder over ~valid returning tag and found.

Verification
REQ-035 SHALL cover sequential allocation: 4 allocs from reset -> tags 0,1,2,3; cur_mask 4'b1111; alloc_ready = 0 on fifth request.
REQ-036 SHALL cover a correct prediction: alloc tags 0,1; resolve tag 0 with taken = pred = 1 -> next cycle broadcast, tag 0, clean = 1; cur_mask 4'b0010; dep_mask[1] = 0.
REQ-037 SHALL cover a mispredict with younger tags: alloc 0,1,2; resolve tag 1 with taken = 1, pred = 0 -> kill tag 1; cur_mask 4'b0001; alloc_ready = 0 during the kill cycle; next alloc returns tag 1.
REQ-038 SHALL cover a same-cycle race: kill of tag 0 broadcast while a resolution for tag 2 (dep on 0) arrives -> no broadcast for tag 2 in the following cycle.
REQ-039 SHALL cover a stale resolution: resolve invalid tag 3 -> no broadcast, state unchanged.
REQ-040 SHALL cover reset mid-operation: rst low while a resolution is registered -> no broadcast follows; cur_mask = 0; alloc_tag = 0.
